// File: rtl/sevenseg_scan_pkg.sv
// ---------------------------------------------------------------------------
// nl_pkg -- shared constants for the seven-segment scan display.
//   * SEG_0..SEG_9, SEG_DASH : segment patterns {g,f,e,d,c,b,a}, active-high
//   * DIG_HT..DIG_SO         : digit index of each BCD digit (5..0)
//   * NDIG                   : number of scanned digits
// ---------------------------------------------------------------------------
package nl_pkg;

    localparam int NDIG = 6;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

    localparam logic [2:0] DIG_HT = 3'd5;  // hours tens
    localparam logic [2:0] DIG_HO = 3'd4;  // hours ones
    localparam logic [2:0] DIG_MT = 3'd3;  // minutes tens
    localparam logic [2:0] DIG_MO = 3'd2;  // minutes ones
    localparam logic [2:0] DIG_ST = 3'd1;  // seconds tens
    localparam logic [2:0] DIG_SO = 3'd0;  // seconds ones

endpackage

// File: rtl/sevenseg_scan_if.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_if -- timer-to-display bundle.
//   tick        : 1 Hz one-cycle pulse from the timer
//   x5..x0      : BCD digits HH:MM:SS
//   seg/an/dp   : segment pattern, digit enables, colon dot
//   expired     : snapshot is 00:00:00
// master = timer/driver side, slave = sevenseg_scan.
// ---------------------------------------------------------------------------
interface sevenseg_scan_if;
    logic       tick;
    logic [3:0] x5;
    logic [3:0] x4;
    logic [3:0] x3;
    logic [3:0] x2;
    logic [3:0] x1;
    logic [3:0] x0;
    logic [6:0] seg;
    logic [5:0] an;
    logic       dp;
    logic       expired;

    modport master (output tick, x5, x4, x3, x2, x1, x0,
                    input  seg, an, dp, expired);
    modport slave  (input  tick, x5, x4, x3, x2, x1, x0,
                    output seg, an, dp, expired);
endinterface

// File: rtl/sevenseg_scan_dec.sv
// ---------------------------------------------------------------------------
// bcd_to_seg -- combinational BCD to seven-segment decoder.
//   bcd : 4-bit digit in
//   seg : {g,f,e,d,c,b,a} active-high; values above 9 show a dash
// ---------------------------------------------------------------------------
module bcd_to_seg
    import nl_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pattern lookup; any non-decimal code falls through to the dash.
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan.sv
// ---------------------------------------------------------------------------
// sevenseg_scan -- six-digit multiplexed display driver for the countdown
// timer. Snapshots the BCD digits once per scan frame, scans one digit per
// SCAN_DIV cycles with a BLANK_CYC dead band, blanks leading zeros, blinks
// the colon on each tick and flashes the display once the snapshot is zero.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : sevenseg_scan_if.slave (tick, x5..x0 in; seg, an, dp, expired out)
// ---------------------------------------------------------------------------
module sevenseg_scan
    import nl_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYC    = 2,
    parameter int FLASH_FRAMES = 64,
    parameter int LZB          = 1
)(
    input  logic            clk,
    input  logic            rst_n,
    sevenseg_scan_if.slave  bus
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic LZB_EN = (LZB != 0);

    logic [PW-1:0]          pre_r;
    logic [2:0]             idx_r;
    logic [NDIG-1:0][3:0]   snap_r;
    logic                   first_r;
    logic                   snap_done_r;
    logic                   expired_r;
    logic [FW-1:0]          flash_cnt_r;
    logic                   flash_off_r;
    logic                   colon_on_r;
    logic [6:0]             seg_r;
    logic [5:0]             an_r;
    logic                   dp_r;

    logic                   pre_tc_s;
    logic                   wrap_s;
    logic                   take_s;
    logic                   all_zero_s;
    logic                   flash_off_s;
    logic [NDIG-1:0]        zero_s;
    logic [NDIG-1:0]        blank_s;
    logic [3:0]             cur_digit_s;
    logic [6:0]             cur_seg_s;
    logic [5:0]             onehot_s;
    logic [5:0]             an_next_s;
    logic                   dp_next_s;

    assign pre_tc_s   = (pre_r == PW'(SCAN_DIV - 1));
    assign wrap_s     = pre_tc_s && (idx_r == DIG_HT);
    // First cycle after reset release also loads, so the display is live at once.
    assign take_s     = wrap_s || first_r;
    assign all_zero_s = (snap_r == 24'd0);
    // Expired gates the flash directly so the display comes back as soon as
    // expired drops, without waiting for the flash register to clear.
    assign flash_off_s = flash_off_r && expired_r;

    assign zero_s[0] = (snap_r[0] == 4'd0);
    assign zero_s[1] = (snap_r[1] == 4'd0);
    assign zero_s[2] = (snap_r[2] == 4'd0);
    assign zero_s[3] = (snap_r[3] == 4'd0);
    assign zero_s[4] = (snap_r[4] == 4'd0);
    assign zero_s[5] = (snap_r[5] == 4'd0);

    // A digit is a leading zero only if it and every digit above it are zero.
    assign blank_s[5] = LZB_EN && zero_s[5];
    assign blank_s[4] = LZB_EN && zero_s[5] && zero_s[4];
    assign blank_s[3] = LZB_EN && zero_s[5] && zero_s[4] && zero_s[3];
    assign blank_s[2] = LZB_EN && zero_s[5] && zero_s[4] && zero_s[3] && zero_s[2];
    assign blank_s[1] = 1'b0;
    assign blank_s[0] = 1'b0;

    // Slot prescaler and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r <= '0;
            idx_r <= 3'd0;
        end else if (pre_tc_s) begin
            pre_r <= '0;
            idx_r <= (idx_r >= DIG_HT) ? 3'd0 : idx_r + 3'd1;
        end else begin
            pre_r <= pre_r + PW'(1);
        end
    end

    // Frame snapshot of the six input digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_r     <= 1'b1;
            snap_done_r <= 1'b0;
            snap_r      <= 24'd0;
        end else begin
            first_r     <= 1'b0;
            snap_done_r <= take_s;
            if (take_s) begin
                snap_r <= {bus.x5, bus.x4, bus.x3, bus.x2, bus.x1, bus.x0};
            end
        end
    end

    // Expired flag, refreshed only in the cycle after a snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expired_r <= 1'b0;
        end else if (snap_done_r) begin
            expired_r <= all_zero_s;
        end
    end

    // Expired flash: frame counter and on/off phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_cnt_r <= '0;
            flash_off_r <= 1'b0;
        end else if (!expired_r) begin
            flash_cnt_r <= '0;
            flash_off_r <= 1'b0;
        end else if (wrap_s) begin
            if (flash_cnt_r == FW'(FLASH_FRAMES - 1)) begin
                flash_cnt_r <= '0;
                flash_off_r <= ~flash_off_r;
            end else begin
                flash_cnt_r <= flash_cnt_r + FW'(1);
            end
        end
    end

    // Colon blink on every tick pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            colon_on_r <= 1'b1;
        end else if (bus.tick) begin
            colon_on_r <= ~colon_on_r;
        end
    end

    // Select the snapshot digit for the current slot.
    always_comb begin
        cur_digit_s = 4'd0;
        case (idx_r)
            DIG_SO:  cur_digit_s = snap_r[0];
            DIG_ST:  cur_digit_s = snap_r[1];
            DIG_MO:  cur_digit_s = snap_r[2];
            DIG_MT:  cur_digit_s = snap_r[3];
            DIG_HO:  cur_digit_s = snap_r[4];
            DIG_HT:  cur_digit_s = snap_r[5];
            default: cur_digit_s = 4'd0;
        endcase
    end

    bcd_to_seg u_dec (
        .bcd (cur_digit_s),
        .seg (cur_seg_s)
    );

    // Enable and colon-dot selection for the next output cycle.
    always_comb begin
        onehot_s  = 6'd0;
        an_next_s = 6'd0;
        dp_next_s = colon_on_r && ((idx_r == DIG_HO) || (idx_r == DIG_MO));
        if (idx_r <= DIG_HT) begin
            onehot_s = 6'b000001 << idx_r;
        end else begin
            onehot_s = 6'd0;
        end
        if ((pre_r < PW'(BLANK_CYC)) || flash_off_s) begin
            an_next_s = 6'd0;
        end else begin
            an_next_s = onehot_s & ~blank_s;
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r <= 7'd0;
            an_r  <= 6'd0;
            dp_r  <= 1'b0;
        end else begin
            seg_r <= cur_seg_s;
            an_r  <= an_next_s;
            dp_r  <= dp_next_s;
        end
    end

    assign bus.seg     = seg_r;
    assign bus.an      = an_r;
    assign bus.dp      = dp_r;
    assign bus.expired = expired_r;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Testbench for sevenseg_scan with SCAN_DIV=4, BLANK_CYC=1, FLASH_FRAMES=2:
// one digit slot is 4 cycles, one frame is 24 cycles. k counts clock edges
// since the last reset release; the output seen after edge k belongs to
// slot (k-1)/4 % 6, slot cycle (k-1) % 4.
module tb_sevenseg_scan;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   k = 0;

    sevenseg_scan_if bus();

    sevenseg_scan #(
        .SCAN_DIV     (4),
        .BLANK_CYC    (1),
        .FLASH_FRAMES (2),
        .LZB          (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        k = k + 1;
        #1;
    endtask

    task automatic set_digits(input logic [3:0] a5, a4, a3, a2, a1, a0);
        bus.x5 = a5; bus.x4 = a4; bus.x3 = a3;
        bus.x2 = a2; bus.x1 = a1; bus.x0 = a0;
    endtask

    // Apply digits and run to the next frame wrap, which snapshots them.
    task automatic load_frame(input logic [3:0] a5, a4, a3, a2, a1, a0);
        set_digits(a5, a4, a3, a2, a1, a0);
        do step(); while (k % 24 != 0);
    endtask

    task automatic test_reset();
        logic [5:0][6:0] es;
        logic [5:0] exp_an;
        logic exp_dp;
        int d, pos;
        es = {7'h6D, 7'h6F, 7'h6D, 7'h6F, 7'h6D, 7'h6F};
        rst_n = 1'b0;
        bus.tick = 1'b0;
        set_digits(4'd5, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.seg !== 7'h00) begin errors++; $display("FAIL reset_seg got %h want 00", bus.seg); end
        checks++; if (bus.an !== 6'h00) begin errors++; $display("FAIL reset_an got %b want 000000", bus.an); end
        checks++; if (bus.dp !== 1'b0) begin errors++; $display("FAIL reset_dp got %b want 0", bus.dp); end
        checks++; if (bus.expired !== 1'b0) begin errors++; $display("FAIL reset_expired got %b want 0", bus.expired); end
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        for (int c = 0; c < 24; c++) begin
            step();
            d = c / 4; pos = c % 4;
            exp_an = (pos == 0) ? 6'd0 : (6'd1 << d);
            exp_dp = (d == 4) || (d == 2);
            checks++; if (bus.an !== exp_an) begin errors++; $display("FAIL reset_walk_an c=%0d got %b want %b", c, bus.an, exp_an); end
            if (c != 0) begin
                checks++; if (bus.seg !== es[d]) begin errors++; $display("FAIL reset_walk_seg c=%0d got %h want %h", c, bus.seg, es[d]); end
            end
            checks++; if (bus.dp !== exp_dp) begin errors++; $display("FAIL reset_walk_dp c=%0d got %b want %b", c, bus.dp, exp_dp); end
            checks++; if (bus.expired !== 1'b0) begin errors++; $display("FAIL reset_walk_expired c=%0d got %b want 0", c, bus.expired); end
        end
    endtask

    task automatic test_snapshot();
        logic [5:0][6:0] es;
        logic [6:0] exp_seg;
        int d;
        es = {7'h6D, 7'h6F, 7'h6D, 7'h6F, 7'h6D, 7'h6F};
        for (int c = 0; c < 48; c++) begin
            step();
            d = (c % 24) / 4;
            exp_seg = (c >= 24 && d == 0) ? 7'h4F : es[d];
            checks++; if (bus.seg !== exp_seg) begin errors++; $display("FAIL snapshot_seg c=%0d got %h want %h", c, bus.seg, exp_seg); end
            if (c == 12) bus.x0 = 4'd3;
        end
    endtask

    task automatic test_blank();
        logic [5:0][6:0] es;
        logic [5:0] een;
        logic [5:0] exp_an;
        int d, pos;
        load_frame(4'd0, 4'd0, 4'd0, 4'd7, 4'd0, 4'd4);
        es  = {7'h3F, 7'h3F, 7'h3F, 7'h07, 7'h3F, 7'h66};
        een = 6'b000111;
        for (int c = 0; c < 24; c++) begin
            step();
            d = c / 4; pos = c % 4;
            exp_an = (pos == 0 || !een[d]) ? 6'd0 : (6'd1 << d);
            checks++; if (bus.an !== exp_an) begin errors++; $display("FAIL blank_an c=%0d got %b want %b", c, bus.an, exp_an); end
            checks++; if (bus.seg !== es[d]) begin errors++; $display("FAIL blank_seg c=%0d got %h want %h", c, bus.seg, es[d]); end
        end
    endtask

    task automatic test_dash();
        logic [5:0][6:0] es;
        logic [5:0] een;
        logic [5:0] exp_an;
        int d, pos;
        load_frame(4'd0, 4'd0, 4'd12, 4'd0, 4'd0, 4'd0);
        es  = {7'h3F, 7'h3F, 7'h40, 7'h3F, 7'h3F, 7'h3F};
        een = 6'b001111;
        for (int c = 0; c < 24; c++) begin
            step();
            d = c / 4; pos = c % 4;
            exp_an = (pos == 0 || !een[d]) ? 6'd0 : (6'd1 << d);
            checks++; if (bus.an !== exp_an) begin errors++; $display("FAIL dash_an c=%0d got %b want %b", c, bus.an, exp_an); end
            checks++; if (bus.seg !== es[d]) begin errors++; $display("FAIL dash_seg c=%0d got %h want %h", c, bus.seg, es[d]); end
        end
    endtask

    task automatic test_colon();
        logic [5:0][6:0] es;
        logic exp_dp;
        int d;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        while (k % 24 != 0) step();
        es = {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D};
        for (int c = 0; c < 24; c++) begin
            step();
            d = c / 4;
            checks++; if (bus.dp !== 1'b0) begin errors++; $display("FAIL colon_off_dp c=%0d got %b want 0", c, bus.dp); end
            checks++; if (bus.seg !== es[d]) begin errors++; $display("FAIL colon_off_seg c=%0d got %h want %h", c, bus.seg, es[d]); end
        end
        repeat (23) step();
        set_digits(4'd2, 4'd3, 4'd0, 4'd8, 4'd5, 4'd9);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        es = {7'h5B, 7'h4F, 7'h3F, 7'h7F, 7'h6D, 7'h6F};
        for (int c = 0; c < 24; c++) begin
            step();
            d = c / 4;
            exp_dp = (d == 4) || (d == 2);
            checks++; if (bus.dp !== exp_dp) begin errors++; $display("FAIL colon_wrap_dp c=%0d got %b want %b", c, bus.dp, exp_dp); end
            checks++; if (bus.seg !== es[d]) begin errors++; $display("FAIL colon_wrap_seg c=%0d got %h want %h", c, bus.seg, es[d]); end
        end
    endtask

    task automatic test_expired();
        logic [5:0] exp_an;
        logic [6:0] exp_seg;
        logic dark;
        int d, pos;
        load_frame(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        checks++; if (bus.expired !== 1'b0) begin errors++; $display("FAIL expired_pre got %b want 0", bus.expired); end
        for (int f = 0; f < 5; f++) begin
            dark = (f == 2) || (f == 3);
            for (int c = 0; c < 24; c++) begin
                step();
                d = c / 4; pos = c % 4;
                exp_an = (dark || pos == 0 || d > 1) ? 6'd0 : (6'd1 << d);
                checks++; if (bus.an !== exp_an) begin errors++; $display("FAIL expired_an f=%0d c=%0d got %b want %b", f, c, bus.an, exp_an); end
                checks++; if (bus.seg !== 7'h3F) begin errors++; $display("FAIL expired_seg f=%0d c=%0d got %h want 3f", f, c, bus.seg); end
                checks++; if (bus.expired !== 1'b1) begin errors++; $display("FAIL expired_flag f=%0d c=%0d got %b want 1", f, c, bus.expired); end
            end
        end
        bus.x0 = 4'd1;
        do step(); while (k % 24 != 0);
        for (int c = 0; c < 24; c++) begin
            step();
            d = c / 4; pos = c % 4;
            exp_an  = (pos == 0 || d > 1) ? 6'd0 : (6'd1 << d);
            exp_seg = (d == 0) ? 7'h06 : 7'h3F;
            checks++; if (bus.an !== exp_an) begin errors++; $display("FAIL resume_an c=%0d got %b want %b", c, bus.an, exp_an); end
            checks++; if (bus.seg !== exp_seg) begin errors++; $display("FAIL resume_seg c=%0d got %h want %h", c, bus.seg, exp_seg); end
            checks++; if (bus.expired !== 1'b0) begin errors++; $display("FAIL resume_expired c=%0d got %b want 0", c, bus.expired); end
        end
    endtask

    task automatic test_async_reset();
        logic [5:0] exp_an;
        logic [6:0] exp_seg;
        int d, pos;
        load_frame(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        repeat (14) step();
        checks++; if (bus.an !== 6'b001000) begin errors++; $display("FAIL async_pre_an got %b want 001000", bus.an); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.seg !== 7'h00) begin errors++; $display("FAIL async_seg got %h want 00", bus.seg); end
        checks++; if (bus.an !== 6'h00) begin errors++; $display("FAIL async_an got %b want 000000", bus.an); end
        checks++; if (bus.dp !== 1'b0) begin errors++; $display("FAIL async_dp got %b want 0", bus.dp); end
        checks++; if (bus.expired !== 1'b0) begin errors++; $display("FAIL async_expired got %b want 0", bus.expired); end
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            d = c / 4; pos = c % 4;
            exp_an  = (pos == 0) ? 6'd0 : (6'd1 << d);
            exp_seg = (d == 0) ? 7'h7D : 7'h6D;
            checks++; if (bus.an !== exp_an) begin errors++; $display("FAIL async_restart_an c=%0d got %b want %b", c, bus.an, exp_an); end
            if (c != 0) begin
                checks++; if (bus.seg !== exp_seg) begin errors++; $display("FAIL async_restart_seg c=%0d got %h want %h", c, bus.seg, exp_seg); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_snapshot();
        test_blank();
        test_dash();
        test_colon();
        test_expired();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
